// File: rtl/clk_div_multi.sv
// clk_div_multi: N-channel programmable clock divider.
//   Each channel toggles its sclk output every D+1 clocks, where D is that
//   channel's active divisor. Each toggle raises a one-cycle tick strobe.
//   A divisor written at run time waits in a pending slot and is taken over
//   at the next terminal count, so no half-period is ever cut or stretched.
//   sync restarts every enabled channel from phase zero.
// Ports:
//   clk      system clock, all logic on posedge
//   rst_n    synchronous reset, active low
//   en       per-channel run enable
//   sync     phase-align pulse for all enabled channels
//   wr_en    divisor write strobe
//   wr_sel   channel index for the write (out-of-range index is ignored)
//   wr_data  new divisor value
//   sclk     divided clock outputs (registered)
//   tick     one-cycle strobe in the cycle sclk toggles (registered)
//   pending  divisor written but not yet applied (registered)
module clk_div_multi #(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEFAULT_DIV = 100000
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [N_CH-1:0]                      en,
   input  logic                                 sync,
   input  logic                                 wr_en,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] wr_sel,
   input  logic [WIDTH-1:0]                     wr_data,
   output logic [N_CH-1:0]                      sclk,
   output logic [N_CH-1:0]                      tick,
   output logic [N_CH-1:0]                      pending
);

   localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [WIDTH-1:0] cnt      [N_CH];
   logic [WIDTH-1:0] div_act  [N_CH];
   logic [WIDTH-1:0] div_pend [N_CH];
   logic [N_CH-1:0]  wr_hit;
   logic [N_CH-1:0]  term;

   // Decode the write target; an index >= N_CH matches no channel.
   always_comb begin
      wr_hit = '0;
      term   = '0;
      for (int i = 0; i < N_CH; i++) begin
         wr_hit[i] = wr_en && (wr_sel == SEL_W'(i));
         term[i]   = (cnt[i] == div_act[i]);
      end
   end

   // Per-channel counter, divisor reload and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            cnt[i]      <= '0;
            div_act[i]  <= WIDTH'(DEFAULT_DIV);
            div_pend[i] <= '0;
         end
         sclk    <= '0;
         tick    <= '0;
         pending <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (!en[i] || sync) begin
               // Idle or phase restart: a safe point to take a new divisor.
               cnt[i]  <= '0;
               sclk[i] <= 1'b0;
               tick[i] <= 1'b0;
               if (en[i] && wr_hit[i]) begin
                  div_act[i] <= wr_data;
                  pending[i] <= 1'b0;
               end else if (wr_hit[i]) begin
                  div_pend[i] <= wr_data;
                  pending[i]  <= 1'b1;
               end else if (pending[i]) begin
                  div_act[i] <= div_pend[i];
                  pending[i] <= 1'b0;
               end
            end else if (term[i]) begin
               cnt[i]  <= '0;
               sclk[i] <= ~sclk[i];
               tick[i] <= 1'b1;
               // A write landing on the terminal count bypasses the pending slot.
               if (wr_hit[i]) begin
                  div_act[i] <= wr_data;
                  pending[i] <= 1'b0;
               end else if (pending[i]) begin
                  div_act[i] <= div_pend[i];
                  pending[i] <= 1'b0;
               end
            end else begin
               cnt[i]  <= cnt[i] + WIDTH'(1);
               tick[i] <= 1'b0;
               if (wr_hit[i]) begin
                  div_pend[i] <= wr_data;
                  pending[i]  <= 1'b1;
               end
            end
         end
      end
   end

endmodule
